// File: rtl/bcd_to_bin.sv
// Purpose: sequential packed-BCD to unsigned binary converter (reverse double dabble).
// Latency: rdy pulses 2*BIN_W+1 clocks after the en edge; busy covers the whole conversion.
// Backpressure: none; en while busy is dropped, so the producer must wait for rdy before restarting.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   en          - single-cycle start request, honoured only while busy=0
//   bcd_d_in    - DIGITS packed BCD digits, digit 0 in [3:0]
//   bin_d_out   - converted value, held until the next completion (0 when err)
//   rdy         - one-clock completion pulse
//   busy        - high while a conversion is in flight
//   err         - set with rdy when any input digit was > 9; held until next completion
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_d_in,
    output logic [BIN_W-1:0]      bin_d_out,
    output logic                  rdy,
    output logic                  busy,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // {bcd_sr, bin_sr}: BCD digits drain out of the bottom into the binary half.
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_nxt;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              err_int;
    logic              err_int_nxt;
    logic              bad_digit;

    logic [BIN_W-1:0]  bin_nxt;
    logic              rdy_nxt;
    logic              busy_nxt;
    logic              err_nxt;

    // Any input digit outside 0..9 poisons the result.
    always_comb begin
        bad_digit = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_d_in[4*d +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // A digit >= 8 after the shift carried a 10 from the digit above, which
    // is worth 8 here only as a 5; subtracting 3 restores the decimal weight.
    // Digit MSB set is exactly the >= 8 condition, so the subtract cannot wrap.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[BIN_W + 4*d + 3]) begin
                sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = en ? SHIFT : IDLE;
            SHIFT:   state_nxt = ADJUST;
            ADJUST:  state_nxt = (cnt == CNT_LAST) ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        sr_nxt      = sr;
        cnt_nxt     = cnt;
        err_int_nxt = err_int;
        bin_nxt     = bin_d_out;
        err_nxt     = err;
        busy_nxt    = busy;
        rdy_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    sr_nxt      = {bcd_d_in, {BIN_W{1'b0}}};
                    err_int_nxt = bad_digit;
                    cnt_nxt     = '0;
                    busy_nxt    = 1'b1;
                end
            end
            SHIFT: begin
                sr_nxt  = sr >> 1;
                cnt_nxt = cnt + 1'b1;
            end
            ADJUST: begin
                sr_nxt = sr_adj;
            end
            DONE: begin
                bin_nxt  = err_int ? '0 : sr[BIN_W-1:0];
                err_nxt  = err_int;
                rdy_nxt  = 1'b1;
                busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            err_int   <= 1'b0;
            bin_d_out <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            err_int   <= err_int_nxt;
            bin_d_out <= bin_nxt;
            rdy       <= rdy_nxt;
            busy      <= busy_nxt;
            err       <= err_nxt;
        end
    end

endmodule
